// File: rtl/vc_test_pkg.sv
// Shared constants for the test sink blocks: LFSR geometry, taps and default seed.
package vc_test_pkg;

    localparam int c_lfsr_nbits = 16;
    // x^16+x^14+x^13+x^11+1 in right-shifting form: feedback from bits 0,2,3,5.
    localparam logic [c_lfsr_nbits-1:0] c_lfsr_taps = 16'h002D;
    localparam logic [c_lfsr_nbits-1:0] c_lfsr_seed = 16'hACE1;

endpackage

// File: rtl/vc_lfsr16.sv
// 16-bit Fibonacci LFSR; shifts right and feeds the tap parity into the MSB when enabled.
module vc_lfsr16
    import vc_test_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic [c_lfsr_nbits-1:0] seed,
    output logic [c_lfsr_nbits-1:0] out
);

    always_ff @(posedge clk) begin
        if (reset) begin
            out <= seed;
        end else if (en) begin
            out <= {^(out & c_lfsr_taps), out[c_lfsr_nbits-1:1]};
        end
    end

endmodule

// File: rtl/vc_test_rand_delay_tag_sink.sv
// Test sink that checks tagged messages in per-tag order against a preloaded table,
// stalling a pseudo-random number of cycles after every accepted message.
module vc_test_rand_delay_tag_sink
    import vc_test_pkg::*;
#(
    parameter int                    p_msg_nbits       = 8,
    parameter int                    p_entries_per_tag = 16,
    parameter int                    p_tag_nbits       = 2,
    parameter int                    p_tag_offset      = 0,
    parameter int                    p_max_delay       = 0,
    parameter logic [c_lfsr_nbits-1:0] p_lfsr_seed     = c_lfsr_seed
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   val,
    output logic                   rdy,
    input  logic [p_msg_nbits-1:0] msg,
    output logic                   done,
    output logic                   err,
    output logic [15:0]            num_failed
);

    localparam int c_num_tags   = 2 ** p_tag_nbits;
    localparam int c_depth      = c_num_tags * p_entries_per_tag;
    localparam int c_addr_nbits = $clog2(c_depth);
    localparam int c_cnt_nbits  = $clog2(p_entries_per_tag + 1);
    localparam logic [c_lfsr_nbits-1:0] c_dly_mask = c_lfsr_nbits'(p_max_delay);

    if (p_tag_offset + p_tag_nbits > p_msg_nbits) begin : g_bad_tag_field
        $error("tag field does not fit inside the message");
    end
    if (p_max_delay < 0 || p_max_delay > 255 || ((p_max_delay + 1) & p_max_delay) != 0) begin : g_bad_max_delay
        $error("p_max_delay must be 2^k-1 with k in 0..8");
    end

    // Expected-message table and per-tag counts are loaded externally; reset leaves them alone.
    logic [p_msg_nbits-1:0]  m   [c_depth];
    logic [c_cnt_nbits-1:0]  n   [c_num_tags];
    logic [c_cnt_nbits-1:0]  idx [c_num_tags];

    logic [c_lfsr_nbits-1:0] dly_cnt;
    logic [c_lfsr_nbits-1:0] lfsr;
    logic [p_tag_nbits-1:0]  tag;
    logic [c_addr_nbits-1:0] addr;
    logic                    xfer;
    logic                    in_range;
    logic                    fail;

    assign rdy      = (dly_cnt == '0) && !reset;
    assign xfer     = val && rdy;
    assign tag      = msg[p_tag_offset +: p_tag_nbits];
    assign addr     = c_addr_nbits'(tag) * c_addr_nbits'(p_entries_per_tag) + c_addr_nbits'(idx[tag]);
    assign in_range = idx[tag] < n[tag];
    assign fail     = xfer && (!in_range || (msg != m[addr]));

    vc_lfsr16 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .en    (xfer),
        .seed  (p_lfsr_seed),
        .out   (lfsr)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            dly_cnt <= '0;
        end else if (xfer) begin
            dly_cnt <= lfsr & c_dly_mask;
        end else if (dly_cnt != '0) begin
            dly_cnt <= dly_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int t = 0; t < c_num_tags; t++) begin
                idx[t] <= '0;
            end
        end else if (xfer && in_range) begin
            idx[tag] <= idx[tag] + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            num_failed <= '0;
            err        <= 1'b0;
        end else if (fail) begin
            err <= 1'b1;
            if (num_failed != 16'hFFFF) begin
                num_failed <= num_failed + 1'b1;
            end
        end
    end

    always_comb begin
        done = 1'b1;
        for (int t = 0; t < c_num_tags; t++) begin
            if (idx[t] != n[t]) begin
                done = 1'b0;
            end
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (fail && in_range) begin
            $display("tag_sink: tag %0d slot %0d expected %h actual %h", tag, idx[tag], m[addr], msg);
        end else if (fail) begin
            $display("tag_sink: tag %0d slot %0d expected none actual %h", tag, idx[tag], msg);
        end
    end
`endif

endmodule

// File: tb/tb_vc_test_rand_delay_tag_sink.sv
// Randomized self-checking bench: per-tag expected queues and a reference LFSR predict the sink.
module tb_vc_test_rand_delay_tag_sink;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, val0, rdy0, done0, err0;
    logic [9:0]  msg0;
    logic [15:0] nf0;
    logic        rst7, val7, rdy7, done7, err7;
    logic [9:0]  msg7;
    logic [15:0] nf7;

    vc_test_rand_delay_tag_sink #(
        .p_msg_nbits(10), .p_entries_per_tag(16), .p_tag_nbits(2),
        .p_tag_offset(8), .p_max_delay(0), .p_lfsr_seed(16'hACE1)
    ) dut0 (
        .clk(clk), .reset(rst0), .val(val0), .rdy(rdy0), .msg(msg0),
        .done(done0), .err(err0), .num_failed(nf0)
    );

    vc_test_rand_delay_tag_sink #(
        .p_msg_nbits(10), .p_entries_per_tag(16), .p_tag_nbits(2),
        .p_tag_offset(8), .p_max_delay(7), .p_lfsr_seed(16'hACE1)
    ) dut7 (
        .clk(clk), .reset(rst7), .val(val7), .rdy(rdy7), .msg(msg7),
        .done(done7), .err(err7), .num_failed(nf7)
    );

    int n_cmp = 0;
    int n_mis = 0;
    int model_fail;
    logic [9:0] tbl   [4][$];
    logic [9:0] exp_q [4][$];
    logic [9:0] ord_a [8] = '{10'h0aa, 10'h1bb, 10'h2cc, 10'h3dd, 10'h0ee, 10'h1ff, 10'h2ab, 10'h3cd};
    logic [9:0] ord_b [8] = '{10'h1bb, 10'h0aa, 10'h3dd, 10'h2cc, 10'h1ff, 10'h0ee, 10'h3cd, 10'h2ab};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        logic [15:0] b;
        b = ((s >> 0) ^ (s >> 2) ^ (s >> 3) ^ (s >> 5)) & 16'd1;
        return (s >> 1) | (b << 15);
    endfunction

    function automatic logic model_done();
        for (int t = 0; t < 4; t++) begin
            if (exp_q[t].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic void set_std_tbl();
        for (int t = 0; t < 4; t++) tbl[t].delete();
        for (int k = 0; k < 8; k++) tbl[ord_a[k][9:8]].push_back(ord_a[k]);
    endfunction

    function automatic void model_reload();
        for (int t = 0; t < 4; t++) exp_q[t] = tbl[t];
        model_fail = 0;
    endfunction

    task automatic load0();
        for (int t = 0; t < 4; t++) begin
            dut0.n[t] = 5'(tbl[t].size());
            for (int s = 0; s < tbl[t].size(); s++) dut0.m[t*16 + s] = tbl[t][s];
        end
        model_reload();
    endtask

    task automatic reset0();
        rst0 = 1'b1;
        val0 = 1'b0;
        msg0 = '0;
        load0();
        step();
        step();
        check_eq("reset_rdy", rdy0, 0);
        check_eq("reset_nfail", nf0, 0);
        check_eq("reset_err", err0, 0);
        check_eq("reset_done", done0, model_done());
        rst0 = 1'b0;
        #1;
        check_eq("first_rdy", rdy0, 1);
    endtask

    task automatic send0(input logic [9:0] v);
        logic [9:0] e;
        int t;
        val0 = 1'b1;
        msg0 = v;
        check_eq("rdy_every_cycle", rdy0, 1);
        step();
        val0 = 1'b0;
        t = int'(v[9:8]);
        if (exp_q[t].size() == 0) begin
            model_fail++;
        end else begin
            e = exp_q[t].pop_front();
            if (e != v) model_fail++;
        end
        check_eq("nfail", nf0, model_fail);
        check_eq("err", err0, model_fail != 0);
        check_eq("done", done0, model_done());
    endtask

    initial begin
        logic [15:0] lfsr_m;
        int gap, exp_gap, t, total;
        logic [9:0] v;

        rst0 = 1'b1; val0 = 1'b0; msg0 = '0;
        rst7 = 1'b1; val7 = 1'b0; msg7 = '0;

        // in-order traffic
        set_std_tbl();
        reset0();
        for (int k = 0; k < 8; k++) send0(ord_a[k]);
        check_eq("inorder_done", done0, 1);
        check_eq("inorder_nfail", nf0, 0);

        // cross-tag reordering
        reset0();
        for (int k = 0; k < 8; k++) send0(ord_b[k]);
        check_eq("reorder_done", done0, 1);
        check_eq("reorder_err", err0, 0);

        // single mismatch on tag 0 slot 0
        reset0();
        check_eq("mis_err_before", err0, 0);
        send0(10'h0ab);
        check_eq("mis_err", err0, 1);
        check_eq("mis_nfail", nf0, 1);
        check_eq("mis_idx0", dut0.idx[0], 1);

        // unexpected message on a tag with no expected entries
        set_std_tbl();
        tbl[2].delete();
        reset0();
        send0(10'h2cc);
        check_eq("unexp_nfail", nf0, 1);
        check_eq("unexp_idx2", dut0.idx[2], 0);
        check_eq("unexp_done_early", done0, 0);
        send0(10'h0aa); send0(10'h1bb); send0(10'h3dd);
        send0(10'h0ee); send0(10'h1ff); send0(10'h3cd);
        check_eq("unexp_done", done0, 1);
        check_eq("unexp_nfail_final", nf0, 1);

        // randomized tables and traffic, including corrupt and surplus messages
        for (int r = 0; r < 6; r++) begin
            for (int tt = 0; tt < 4; tt++) begin
                tbl[tt].delete();
                for (int s = 0; s < int'($urandom_range(0, 4)); s++)
                    tbl[tt].push_back({2'(tt), 8'($urandom)});
            end
            reset0();
            for (int k = 0; k < 10; k++) begin
                t = int'($urandom_range(0, 3));
                if (exp_q[t].size() != 0 && ($urandom % 4) != 0) v = exp_q[t][0];
                else v = {2'(t), 8'($urandom)};
                send0(v);
            end
            for (int tt = 0; tt < 4; tt++) begin
                while (exp_q[tt].size() != 0) send0(exp_q[tt][0]);
            end
            check_eq("rand_done", done0, 1);
        end

        // reset in the middle of a stream
        set_std_tbl();
        reset0();
        for (int k = 0; k < 3; k++) send0(ord_a[k]);
        val0 = 1'b1;
        msg0 = ord_a[3];
        rst0 = 1'b1;
        step();
        val0 = 1'b0;
        check_eq("midrst_nfail", nf0, 0);
        check_eq("midrst_done", done0, 0);
        check_eq("midrst_idx0", dut0.idx[0], 0);
        check_eq("midrst_idx3", dut0.idx[3], 0);
        rst0 = 1'b0;
        model_reload();
        #1;
        for (int k = 0; k < 8; k++) send0(ord_a[k]);
        check_eq("midrst_resend_done", done0, 1);
        check_eq("midrst_resend_nfail", nf0, 0);

        // random stall with val held high
        set_std_tbl();
        for (int tt = 0; tt < 4; tt++) begin
            dut7.n[tt] = 5'(tbl[tt].size());
            for (int s = 0; s < tbl[tt].size(); s++) dut7.m[tt*16 + s] = tbl[tt][s];
        end
        step();
        step();
        check_eq("dly_reset_rdy", rdy7, 0);
        rst7 = 1'b0;
        #1;
        val7 = 1'b1;
        lfsr_m = 16'hACE1;
        exp_gap = 0;
        total = 0;
        for (int k = 0; k < 8; k++) begin
            msg7 = ord_a[k];
            gap = 0;
            while (!rdy7 && gap < 20) begin
                step();
                gap++;
            end
            check_eq("dly_gap", gap, exp_gap);
            check_eq("dly_gap_range", gap <= 7, 1);
            step();
            total += gap;
            exp_gap = int'(lfsr_m & 16'd7);
            lfsr_m = lfsr_next(lfsr_m);
        end
        val7 = 1'b0;
        step();
        check_eq("dly_done", done7, 1);
        check_eq("dly_nfail", nf7, 0);
        check_eq("dly_err", err7, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/vc_test_rand_delay_tag_sink.md
VC_TEST_RAND_DELAY_TAG_SINK -- requirements
Module: vc_test_rand_delay_tag_sink

Interface
REQ-001 The block SHALL have parameter p_msg_nbits, default 8: message width in bits.
REQ-002 The block SHALL have parameter p_entries_per_tag, default 16: expected-message slots per tag.
REQ-003 The block SHALL have parameter p_tag_nbits, default 2: tag field width; the number of tags is 2^p_tag_nbits.
REQ-004 The block SHALL have parameter p_tag_offset, default 0: LSB position of the tag field in msg.
REQ-005 The block SHALL have parameter p_max_delay, default 0: maximum random stall in cycles, restricted to 2^k-1 for k in 0..8.
REQ-006 The block SHALL have parameter p_lfsr_seed, default 16'hACE1: LFSR reset value, nonzero.
REQ-007 The block SHALL have port clk, input, 1 bit: the single clock; the block has one clock and reset is synchronous and active-high.
REQ-008 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-009 The block SHALL have port val, input, 1 bit: upstream message valid.
REQ-010 The block SHALL have port rdy, output, 1 bit: sink ready.
REQ-011 The block SHALL have port msg, input, p_msg_nbits bits: message under check.
REQ-012 The block SHALL have port done, output, 1 bit: every tag has received its expected count.
REQ-013 The block SHALL have port err, output, 1 bit: sticky failure flag.
REQ-014 The block SHALL have port num_failed, output, 16 bits: failure count, saturating.

Function
REQ-015 Elaboration SHALL fail if p_tag_offset+p_tag_nbits > p_msg_nbits, or if p_max_delay+1 is not a power of two.
REQ-016 Storage SHALL be m[2^p_tag_nbits*p_entries_per_tag] of p_msg_nbits, indexed {tag, slot}, and n[2^p_tag_nbits] of clog2(p_entries_per_tag+1) bits; the bench loads both hierarchically before reset deasserts, and reset SHALL NOT clear them.
REQ-017 Tag SHALL equal msg[p_tag_offset +: p_tag_nbits].
REQ-018 A transfer SHALL occur in the cycle where val and rdy are both high; with val high and rdy low, nothing is consumed.
REQ-019 rdy SHALL be (dly_cnt==0) and not reset; its value SHALL be independent of val.
REQ-020 On a transfer, dly_cnt SHALL load lfsr & p_max_delay and the LFSR SHALL advance one step; otherwise a nonzero dly_cnt SHALL decrement by 1.
REQ-021 The delay mechanism SHALL therefore hold rdy low for exactly the loaded count of cycles after each transfer; with p_max_delay=0, rdy SHALL be high every non-reset cycle.
REQ-022 The LFSR SHALL be a 16-bit Fibonacci LFSR with polynomial x^16+x^14+x^13+x^11+1 that advances only on transfers.
REQ-023 On a transfer with idx[tag] < n[tag], msg SHALL be compared against m[{tag, idx[tag]}] and idx[tag] SHALL increment by 1.
REQ-024 On a compare mismatch, num_failed SHALL increment and err SHALL set.
REQ-025 On a transfer with idx[tag] == n[tag] (unexpected message), the block SHALL record one failure and leave idx[tag] unchanged.
REQ-026 num_failed SHALL saturate at 16'hFFFF.
REQ-027 done SHALL be the AND over all tags of (idx[t]==n[t]) and SHALL be combinational from registered state; a tag with n=0 SHALL count as complete.
REQ-028 The failure update and the idx update of the same transfer SHALL both take effect at the next clock edge.
REQ-029 Under simulation only, each failure SHALL $display the tag, slot, expected value and actual value.

Reset
REQ-030 While reset is high, the block SHALL set idx[*]=0, dly_cnt=0, lfsr=p_lfsr_seed, num_failed=0 and err=0, and drive rdy=0.
REQ-031 In the first cycle after reset deasserts, rdy SHALL be 1.
REQ-032 A reset asserted mid-stream SHALL discard a transfer in that cycle (no compare, no idx change) and restart checking from slot 0 of every tag.

Structure
REQ-033 A shared package vc_test_pkg SHALL hold the LFSR width, tap mask and default seed constants.
REQ-034 The LFSR SHALL be a sub-module vc_lfsr16 with ports clk, reset, en, seed and out; all other logic is local.

Verification
REQ-035 The bench SHALL cover in-order traffic: 10-bit msgs, p_tag_nbits=2, p_tag_offset=8, source sends 0aa,1bb,2cc,3dd,0ee,1ff,2ab,3cd with n[*]=2 and p_max_delay=0 -> rdy high every cycle, done=1 after the 8th transfer, err=0, num_failed=0.
REQ-036 The bench SHALL cover cross-tag reordering: send 1bb,0aa,3dd,2cc,1ff,0ee,3cd,2ab with the same memory -> done=1, err=0.
REQ-037 The bench SHALL cover a mismatch: m[{0,0}]=0aa and 0ab is sent -> err=1 on the next cycle, num_failed=1, idx[0]=1.
REQ-038 The bench SHALL cover an unexpected message: n[2]=0 and 2cc is sent -> num_failed=1, idx[2]=0, and done is unaffected for the other tags.
REQ-039 The bench SHALL cover random delay: p_max_delay=7 with val held high -> every rdy-low gap is 0..7 cycles, the gap sequence matches the golden LFSR model from seed ACE1, and all messages check clean.
REQ-040 The bench SHALL cover reset mid-stream: assert reset after 3 transfers -> num_failed=0, done=0, and a full resend of all messages completes with done=1.
